// File: rtl/pstore_sat_acc.sv
// pstore_sat_acc: multi-channel saturating weight accumulator.
// Each pass loads a per-channel bias, then sums COUNT signed weight beats
// into OUT_W-bit accumulators with clamp-on-overflow and a sticky flag.
module pstore_sat_acc #(
  parameter int NODES = 4,
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int COUNT = 784
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   start,
  input  logic [NODES*OUT_W-1:0] bias_in,
  input  logic                   in_valid,
  input  logic [NODES*IN_W-1:0]  weights_in,
  output logic                   in_ready,
  output logic [NODES*OUT_W-1:0] sum_out,
  output logic [NODES-1:0]       sat_flag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             load;  // start of a pass: bias reload, flag/count clear
  logic             beat;  // weight beat accepted this cycle

  // State register; reset drops any pass in flight.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load       = 1'b0;
    beat       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          beat = 1'b1;
          if (cnt_reg == LAST_IDX) state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (start) begin
            // Result handed off and next pass begins in the same cycle.
            load       = 1'b1;
            state_next = ACCUM;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  // Beat counter: cleared at pass start, advanced per accepted beat.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)    cnt_reg <= '0;
    else if (load) cnt_reg <= '0;
    else if (beat) cnt_reg <= cnt_reg + 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NODES; gi++) begin : g_ch
      logic [OUT_W-1:0] acc_reg;
      logic             sat_reg;
      logic [IN_W-1:0]  w;
      logic [OUT_W:0]   sum_wide;
      logic [OUT_W-1:0] sum_next;
      logic             ovf;

      assign w = weights_in[gi*IN_W +: IN_W];
      // One guard bit above OUT_W makes overflow visible as a mismatch of
      // the top two bits.
      assign sum_wide = {acc_reg[OUT_W-1], acc_reg}
                      + {{(OUT_W + 1 - IN_W){w[IN_W-1]}}, w};

      // Clamp to the representable range when the guard bit disagrees.
      always_comb begin
        sum_next = sum_wide[OUT_W-1:0];
        ovf      = 1'b0;
        if (sum_wide[OUT_W] != sum_wide[OUT_W-1]) begin
          ovf = 1'b1;
          if (sum_wide[OUT_W]) sum_next = {1'b1, {(OUT_W-1){1'b0}}};
          else                 sum_next = {1'b0, {(OUT_W-1){1'b1}}};
        end
      end

      // Accumulator and sticky saturation flag for this channel.
      always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
          acc_reg <= '0;
          sat_reg <= 1'b0;
        end else if (load) begin
          acc_reg <= bias_in[gi*OUT_W +: OUT_W];
          sat_reg <= 1'b0;
        end else if (beat) begin
          acc_reg <= sum_next;
          if (ovf) sat_reg <= 1'b1;
        end
      end

      assign sum_out[gi*OUT_W +: OUT_W] = acc_reg;
      assign sat_flag[gi]               = sat_reg;
    end
  endgenerate

endmodule
